// File: rtl/instr_fetch_ctrl_if.sv
// Bus bundle between the fetch sequencer, the instruction memory and decode.
// The master modport is the fetch sequencer side; slave is the memory/decode side.
interface instr_fetch_ctrl_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_instr;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        fault;
  logic [15:0] fetch_count;
  logic [1:0]  fsm_state;

  modport master (
    output mem_addr, instr, instr_pc, instr_valid, fault, fetch_count, fsm_state,
    input  mem_instr, instr_ready, redirect, redirect_pc, halt
  );

  modport slave (
    input  mem_addr, instr, instr_pc, instr_valid, fault, fetch_count, fsm_state,
    output mem_instr, instr_ready, redirect, redirect_pc, halt
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, waits RD_WAIT cycles for the combinational
// instruction memory, then offers the captured word to decode.
module instr_fetch_ctrl #(
  parameter int unsigned RD_WAIT  = 2,
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] PC_LIMIT = 32'd40
) (
  input logic               clk,
  input logic               rst_n,
  instr_fetch_ctrl_if.master bus
);

  // fsm_state encoding, visible on bus.fsm_state
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  localparam logic [3:0] LAST_WAIT = 4'(RD_WAIT - 1);

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] instr_q;
  logic [31:0] instr_pc_q;
  logic        valid_q;
  logic        fault_q;
  logic        start_q;
  logic [15:0] count_q;
  logic [3:0]  wait_cnt;
  logic        handshake;
  logic [31:0] pc_inc;

  // Handshake: instr/instr_pc are held while instr_valid is high and transfer
  // on any rising edge where instr_valid && instr_ready; valid never drops
  // without a transfer except on redirect or reset.
  assign handshake = valid_q & bus.instr_ready;
  assign pc_inc    = pc + 32'd4;

  function automatic logic pc_bad(input logic [31:0] p);
    return (p[1:0] != 2'b00) || (p >= PC_LIMIT);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      instr_q    <= 32'd0;
      instr_pc_q <= 32'd0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
      start_q    <= 1'b1;
      count_q    <= 16'd0;
      wait_cnt   <= 4'd0;
    end else begin
      start_q <= 1'b0;
      if (handshake) begin
        count_q <= count_q + 16'd1;
        valid_q <= 1'b0;
      end
      if (bus.redirect) begin
        pc       <= bus.redirect_pc;
        wait_cnt <= 4'd0;
        valid_q  <= 1'b0;
        if (pc_bad(bus.redirect_pc)) begin
          state   <= S_FAULT;
          fault_q <= 1'b1;
        end else begin
          fault_q <= 1'b0;
          state   <= bus.halt ? S_IDLE : S_FETCH;
        end
      end else begin
        case (state)
          S_FETCH: begin
            // start_q marks the fetch boundary right after reset release
            if (start_q && pc_bad(pc)) begin
              state   <= S_FAULT;
              fault_q <= 1'b1;
            end else if (start_q && bus.halt) begin
              state <= S_IDLE;
            end else if (wait_cnt == LAST_WAIT) begin
              instr_q    <= bus.mem_instr;
              instr_pc_q <= pc;
              valid_q    <= 1'b1;
              wait_cnt   <= 4'd0;
              state      <= S_HOLD;
            end else begin
              wait_cnt <= wait_cnt + 4'd1;
            end
          end
          S_HOLD: begin
            if (handshake) begin
              pc <= pc_inc;
              if (pc_bad(pc_inc)) begin
                state   <= S_FAULT;
                fault_q <= 1'b1;
              end else begin
                state <= bus.halt ? S_IDLE : S_FETCH;
              end
            end
          end
          S_IDLE: begin
            if (!bus.halt) begin
              wait_cnt <= 4'd0;
              if (pc_bad(pc)) begin
                state   <= S_FAULT;
                fault_q <= 1'b1;
              end else begin
                state <= S_FETCH;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.mem_addr    = pc;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.fault       = fault_q;
  assign bus.fetch_count = count_q;
  assign bus.fsm_state   = state;

endmodule
